// File: rtl/fetch_ctrl.sv
// ----------------------------------------------------------------------------
// fetch_ctrl
//
// Fetch-stage controller. It sequences the PC register against a wait-stated
// instruction memory port with at most one outstanding request, hands fetched
// words to decode and absorbs decode back-pressure and branch/jump redirects.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   pc_f              current PC from the PC register
//   pc_next, stall_f  next PC and hold control for the PC register
//   hazard_stall      decode cannot accept an instruction this cycle
//   redirect_valid    taken branch/jump. Squashes the in-flight fetch.
//   redirect_target   redirect address. It is word-aligned before use.
//   imem_req/addr     request to instruction memory (addr is always pc_f)
//   imem_gnt          request accepted this cycle
//   imem_rvalid/rdata single-cycle, in-order response
//   instr_f, pc_out_f instruction and its PC to decode
//   valid_f           single-cycle handoff strobe for instr_f/pc_out_f
//   bus_timeout       one-cycle pulse when a response never arrives
//   dbg_state         current FSM state, for observation only
//
// Handshake semantics
//   The memory takes a request in any cycle where imem_req && imem_gnt.
//   Exactly one imem_rvalid pulse answers it, in a later cycle. decode
//   consumes instr_f in any cycle where valid_f is high. valid_f is never
//   raised while hazard_stall or redirect_valid is high. The PC register
//   loads pc_next in every cycle where stall_f is low.
//
// All handoff outputs are combinational from the current state and inputs.
// The fetched word therefore reaches decode in the same cycle as imem_rvalid.
// ----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int TIMEOUT   = 255,
    parameter int TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_f,
    output logic [31:0] pc_next,
    output logic        stall_f,
    input  logic        hazard_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_f,
    output logic [31:0] pc_out_f,
    output logic        valid_f,
    output logic        bus_timeout,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,  // request pc_f on the memory port
        ST_WAIT  = 2'd1,  // request granted, waiting for its response
        ST_HOLD  = 2'd2,  // response buffered, waiting for decode
        ST_DROP  = 2'd3   // squashed request outstanding, discard its response
    } state_t;

    // The counter value seen in the cycle that fires the timeout.
    // The cycle of entry counts as the first cycle, with a count of 0.
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]            buf_q, buf_d;

    logic                   deliver;   // hand a word to decode this cycle
    logic                   tmo_hit;   // response overdue this cycle
    logic [31:0]            pc_plus4;
    logic [31:0]            redir_pc;

    // The low target bits are dropped by the word alignment.
    logic                   unused_tgt_bits;
    assign unused_tgt_bits = ^redirect_target[1:0];

    assign pc_plus4 = pc_f + 32'd4;
    assign redir_pc = {redirect_target[31:2], 2'b00};

    // ------------------------------------------------------------------
    // Next-state decode. A redirect outranks every other event. The
    // hazard_stall input only gates delivery. It never delays a redirect.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        deliver = 1'b0;
        tmo_hit = 1'b0;

        case (state_q)
            ST_ISSUE: begin
                // A response seen here belongs to no live request and is ignored.
                if (imem_gnt) begin
                    // A grant in the same cycle as a redirect leaves a
                    // squashed request in flight. Its response must be drained.
                    state_d = redirect_valid ? ST_DROP : ST_WAIT;
                    cnt_d   = '0;
                end
                // Redirect without a grant: stay here. The request is
                // reissued next cycle at the new pc_f.
            end

            ST_WAIT: begin
                if (redirect_valid) begin
                    if (imem_rvalid) begin
                        state_d = ST_ISSUE;        // stale word dropped at once
                    end else begin
                        state_d = ST_DROP;
                        cnt_d   = '0;
                    end
                end else if (imem_rvalid) begin
                    if (hazard_stall) begin
                        buf_d   = imem_rdata;
                        state_d = ST_HOLD;
                    end else begin
                        deliver = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    // pc_f was held, so ISSUE re-requests the same address.
                    tmo_hit = 1'b1;
                    state_d = ST_ISSUE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_HOLD: begin
                if (redirect_valid) begin
                    state_d = ST_ISSUE;            // buffered word discarded
                end else if (!hazard_stall) begin
                    deliver = 1'b1;
                    state_d = ST_ISSUE;
                end
            end

            ST_DROP: begin
                if (imem_rvalid) begin
                    // The squashed response has arrived. pc_f already
                    // holds the redirect target. This also covers a
                    // second redirect that lands on the same cycle.
                    state_d = ST_ISSUE;
                end else if (redirect_valid) begin
                    cnt_d = '0;                    // fresh redirect restarts the wait
                end else if (cnt_q == TMO_LAST) begin
                    tmo_hit = 1'b1;
                    state_d = ST_ISSUE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: state_d = ST_ISSUE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ISSUE;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Reset forces the port and handoff strobes quiet and holds
    // the PC register, whatever the state register holds at that time.
    // ------------------------------------------------------------------
    assign imem_req    = !reset && (state_q == ST_ISSUE);
    assign imem_addr   = pc_f;

    assign valid_f     = !reset && deliver;
    assign instr_f     = (state_q == ST_HOLD) ? buf_q : imem_rdata;
    assign pc_out_f    = pc_f;

    // The PC moves on a delivery (sequential advance) or on a redirect.
    assign stall_f     = reset || !(redirect_valid || deliver);
    assign pc_next     = (!reset && redirect_valid) ? redir_pc : pc_plus4;

    assign bus_timeout = !reset && tmo_hit;

    assign dbg_state   = state_q;

endmodule
